host_mmio_monitor: RTL and testbench



---
 rtl/pakrv_host_pkg.sv | 14 +
 rtl/sync_fifo.sv | 39 +++
 rtl/host_mmio_monitor.sv | 90 +++++++++
 tb/tb_host_mmio_monitor.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/pakrv_host_pkg.sv
// Shared types and default constants for the host MMIO monitor.
package pakrv_host_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } host_state_e;

  localparam logic [31:0] PAKRV_SIG_ADDR  = 32'h8E00_0000;
  localparam logic [31:0] PAKRV_HALT_ADDR = 32'h8F00_0000;
  localparam int          PAKRV_CNT_WIDTH = 32;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO with wrap-bit pointers; head reads 0 while empty.
module sync_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic                  full,
  output logic                  empty,
  output logic [DATA_WIDTH-1:0] head
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW:0]           wr_ptr, rd_ptr;

  // Storage is intentionally left unreset; only the pointers clear.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/host_mmio_monitor.sv
// Snoops core stores for signature/halt MMIO, buffers signature words, tracks run state.
// Define PAKRV_CYCLE_CNT_EN to build the execution cycle counter; otherwise cycles_o is 0.
module host_mmio_monitor
  import pakrv_host_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] SIG_ADDR   = PAKRV_SIG_ADDR,
  parameter logic [ADDR_WIDTH-1:0] HALT_ADDR  = PAKRV_HALT_ADDR,
  parameter int                    FIFO_DEPTH = 16,
  parameter int                    CNT_WIDTH  = PAKRV_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  write_en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  sig_valid_o,
  output logic [DATA_WIDTH-1:0] sig_data_o,
  input  logic                  sig_ready_i,
  output logic                  halt_o,
  output logic                  done_o,
  output logic                  overflow_o,
  output logic [CNT_WIDTH-1:0]  cycles_o
);

  host_state_e state_q, state_d;
  logic        in_run, sig_hit, halt_hit;
  logic        full, empty, push, pop;
  logic        ovf_q;

  assign in_run   = (state_q == RUN);
  assign sig_hit  = in_run && write_en && (addr == SIG_ADDR);
  assign halt_hit = in_run && write_en && (addr == HALT_ADDR);
  assign pop      = !empty && sig_ready_i;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
  assign push     = sig_hit && (!full || pop);

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .arst_n    (arst_n),
    .push      (push),
    .push_data (data_in),
    .pop       (pop),
    .full      (full),
    .empty     (empty),
    .head      (sig_data_o)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (halt_hit) state_d = DRAIN;
      DRAIN:   if (empty)    state_d = DONE;
      default: state_d = DONE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= RUN;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (sig_hit && full && !pop) ovf_q <= 1'b1;
    end
  end

`ifdef PAKRV_CYCLE_CNT_EN
  logic [CNT_WIDTH-1:0] cnt_q;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n)                      cnt_q <= '0;
    else if (in_run && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
  end

  assign cycles_o = cnt_q;
`else
  assign cycles_o = '0;
`endif

  assign sig_valid_o = !empty;
  assign halt_o      = (state_q != RUN);
  assign done_o      = (state_q == DONE);
  assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_host_mmio_monitor.sv
// Directed self-checking bench for host_mmio_monitor.
module tb_host_mmio_monitor;
  localparam logic [31:0] SIG  = 32'h8E00_0000;
  localparam logic [31:0] HALT = 32'h8F00_0000;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        write_en = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] data_in = '0;
  logic        sig_ready_i = 1'b0;
  logic        sig_valid_o, halt_o, done_o, overflow_o;
  logic [31:0] sig_data_o, cycles_o;

  int checks = 0;
  int passes = 0;

  host_mmio_monitor dut (
    .clk         (clk),
    .arst_n      (arst_n),
    .write_en    (write_en),
    .addr        (addr),
    .data_in     (data_in),
    .sig_valid_o (sig_valid_o),
    .sig_data_o  (sig_data_o),
    .sig_ready_i (sig_ready_i),
    .halt_o      (halt_o),
    .done_o      (done_o),
    .overflow_o  (overflow_o),
    .cycles_o    (cycles_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Drives one store for a single edge; returns at the following negedge.
  task automatic store(input logic [31:0] a, input logic [31:0] d);
    write_en = 1'b1;
    addr     = a;
    data_in  = d;
    @(negedge clk);
    write_en = 1'b0;
    addr     = '0;
    data_in  = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    arst_n      = 1'b0;
    sig_ready_i = 1'b0;
    write_en    = 1'b0;
    @(negedge clk);
    arst_n = 1'b1;
  endtask

  logic [31:0] exp_cyc;

  initial begin
    // Reset state
    #2;
    chk("rst_valid", {31'd0, sig_valid_o}, 32'd0);
    chk("rst_data", sig_data_o, 32'd0);
    chk("rst_flags", {29'd0, halt_o, done_o, overflow_o}, 32'd0);
    chk("rst_cycles", cycles_o, 32'd0);
    @(negedge clk);
    arst_n = 1'b1;

    // Basic push/drain
    sig_ready_i = 1'b1;
    store(SIG, 32'hDEAD_BEEF);
    chk("basic_v0", {31'd0, sig_valid_o}, 32'd1);
    chk("basic_d0", sig_data_o, 32'hDEAD_BEEF);
    store(SIG, 32'h1234_5678);
    chk("basic_v1", {31'd0, sig_valid_o}, 32'd1);
    chk("basic_d1", sig_data_o, 32'h1234_5678);
    @(negedge clk);
    chk("basic_empty", {31'd0, sig_valid_o}, 32'd0);
    chk("basic_ovf", {31'd0, overflow_o}, 32'd0);
    store(32'h8E00_0004, 32'hAAAA_AAAA);
    chk("near_addr", {31'd0, sig_valid_o}, 32'd0);

    // Backpressure: 17 stores into 16 slots
    do_reset();
    for (int k = 1; k <= 17; k++) store(SIG, 32'h100 + k);
    chk("bp_ovf", {31'd0, overflow_o}, 32'd1);
    chk("bp_head", sig_data_o, 32'h101);
    sig_ready_i = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      chk($sformatf("bp_word%0d", i), sig_data_o, 32'h100 + i);
      @(negedge clk);
    end
    chk("bp_drained", {31'd0, sig_valid_o}, 32'd0);

    // Full FIFO push and pop in the same cycle
    do_reset();
    for (int k = 1; k <= 16; k++) store(SIG, 32'h200 + k);
    sig_ready_i = 1'b1;
    store(SIG, 32'h2FF);
    chk("fpp_ovf", {31'd0, overflow_o}, 32'd0);
    for (int i = 2; i <= 16; i++) begin
      chk($sformatf("fpp_word%0d", i), sig_data_o, 32'h200 + i);
      @(negedge clk);
    end
    chk("fpp_last", sig_data_o, 32'h2FF);
    @(negedge clk);
    chk("fpp_drained", {31'd0, sig_valid_o}, 32'd0);
    chk("fpp_ovf_end", {31'd0, overflow_o}, 32'd0);

    // Halt with pending data
    do_reset();
    for (int k = 1; k <= 3; k++) store(SIG, 32'h300 + k);
    store(HALT, 32'hFFFF_FFFF);
    chk("halt_set", {31'd0, halt_o}, 32'd1);
    chk("halt_notdone", {31'd0, done_o}, 32'd0);
    store(SIG, 32'h3AA);
    chk("halt_notdone2", {31'd0, done_o}, 32'd0);
    sig_ready_i = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      chk($sformatf("halt_word%0d", i), sig_data_o, 32'h300 + i);
      @(negedge clk);
    end
    chk("halt_nopush", {31'd0, sig_valid_o}, 32'd0);
    chk("halt_done_lat", {31'd0, done_o}, 32'd0);
    @(negedge clk);
    chk("halt_done", {31'd0, done_o}, 32'd1);
    repeat (3) @(negedge clk);
    chk("done_sticky", {30'd0, halt_o, done_o}, 32'd3);

    // Cycle count: halt store at the 100th RUN cycle
    do_reset();
    repeat (99) @(negedge clk);
`ifdef PAKRV_CYCLE_CNT_EN
    exp_cyc = 32'd99;
`else
    exp_cyc = 32'd0;
`endif
    chk("cyc_99", cycles_o, exp_cyc);
    store(HALT, 32'd0);
`ifdef PAKRV_CYCLE_CNT_EN
    exp_cyc = 32'd100;
`endif
    chk("cyc_100", cycles_o, exp_cyc);
    repeat (50) @(negedge clk);
    chk("cyc_hold", cycles_o, exp_cyc);
    chk("cyc_done", {31'd0, done_o}, 32'd1);

    // Reset mid-drain with 5 words buffered
    do_reset();
    for (int k = 1; k <= 5; k++) store(SIG, 32'h500 + k);
    store(HALT, 32'd0);
    chk("mid_halt", {30'd0, halt_o, sig_valid_o}, 32'd3);
    #1 arst_n = 1'b0;
    #1;
    chk("mid_valid", {31'd0, sig_valid_o}, 32'd0);
    chk("mid_data", sig_data_o, 32'd0);
    chk("mid_flags", {29'd0, halt_o, done_o, overflow_o}, 32'd0);
    chk("mid_cycles", cycles_o, 32'd0);
    @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);
    chk("post_valid", {31'd0, sig_valid_o}, 32'd0);
    chk("post_run", {31'd0, halt_o}, 32'd0);
    store(SIG, 32'h600D_F00D);
    chk("post_push", sig_data_o, 32'h600D_F00D);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
